// File: rtl/boot_pkg.sv
// Shared types and constants for the boot image loader.
package boot_pkg;

  localparam int WORD_W = 32;
  localparam int IDX_W  = 16;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MAGIC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/boot_word_assembler.sv
// Little-endian byte-to-word assembler: first byte lands in bits [7:0].
module boot_word_assembler
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic              word_ready,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        lane_q, lane_d;
  logic [WORD_W-1:0] sr_q, sr_d;

  always_comb begin
    lane_d = lane_q;
    sr_d   = sr_q;
    if (clear) begin
      lane_d = '0;
      sr_d   = '0;
    end else if (byte_valid) begin
      lane_d = lane_q + 2'd1;
      sr_d   = {byte_in, sr_q[WORD_W-1:8]};
    end
  end

  assign word_ready = byte_valid && !clear && (lane_q == 2'd3);
  assign word       = {byte_in, sr_q[WORD_W-1:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      sr_q   <= '0;
    end else begin
      lane_q <= lane_d;
      sr_q   <= sr_d;
    end
  end

endmodule

// File: rtl/boot_image_loader.sv
// Framed boot-image receiver driving the instruction-memory debug write port.
module boot_image_loader
  import boot_pkg::*;
#(
  parameter logic [7:0] MAGIC          = MAGIC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              debug,
  output logic [WORD_W-1:0] data_cpu,
  output logic [WORD_W-1:0] waddr_cpu,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [IDX_W:0]    wcnt_q, wcnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [TW-1:0]     idle_q, idle_d;
  logic              debug_q, debug_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  waddr_q, waddr_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              asm_clear;
  logic              asm_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word;
  logic              timed;

  boot_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_valid),
    .byte_in    (rx_byte),
    .word_ready (word_ready),
    .word       (word)
  );

  assign timed = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                 (state_q == DATA)   || (state_q == CHECK);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wcnt_d    = wcnt_q;
    chk_d     = chk_q;
    idle_d    = idle_q;
    debug_d   = 1'b0;
    data_d    = data_q;
    waddr_d   = waddr_q;
    hold_d    = hold_q;
    done_d    = done_q;
    err_d     = err_q;
    asm_clear = 1'b0;
    asm_valid = 1'b0;

    if (timed) begin
      idle_d = rx_valid ? '0 : idle_q + TW'(1);
    end

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d   = WAIT_MAGIC;
          done_d    = 1'b0;
          err_d     = 1'b0;
          wcnt_d    = '0;
          chk_d     = '0;
          idle_d    = '0;
          hold_d    = 1'b1;
          asm_clear = 1'b1;
        end
      end
      WAIT_MAGIC: begin
        if (rx_valid && rx_byte == MAGIC) begin
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_byte;
          chk_d      = chk_q ^ rx_byte;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (rx_valid) begin
          len_d[15:8] = rx_byte;
          chk_d       = chk_q ^ rx_byte;
          state_d     = ({rx_byte, len_q[7:0]} == '0) ? CHECK : DATA;
        end
      end
      DATA: begin
        if (rx_valid) begin
          asm_valid = 1'b1;
          chk_d     = chk_q ^ rx_byte;
          if (word_ready) begin
            debug_d = 1'b1;
            data_d  = word;
            waddr_d = wcnt_q[IDX_W-1:0];
            wcnt_d  = wcnt_q + 17'd1;
            if (wcnt_d == {1'b0, len_q}) begin
              state_d = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_byte == chk_q) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Silence on the line mid-frame aborts the load.
    if (timed && !rx_valid && idle_d == TW'(TIMEOUT_CYCLES)) begin
      state_d = ERROR;
      err_d   = 1'b1;
      hold_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      chk_q   <= '0;
      idle_q  <= '0;
      debug_q <= 1'b0;
      data_q  <= '0;
      waddr_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      chk_q   <= chk_d;
      idle_q  <= idle_d;
      debug_q <= debug_d;
      data_q  <= data_d;
      waddr_q <= waddr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign debug     = debug_q;
  assign data_cpu  = data_q;
  assign waddr_cpu = {{(WORD_W-IDX_W){1'b0}}, waddr_q};
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign error     = err_q;

endmodule

// File: tb/tb_boot_image_loader.sv
// Self-checking bench: frame table plus timeout and mid-frame reset sequences.
module tb_boot_image_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        debug;
  logic [31:0] data_cpu;
  logic [31:0] waddr_cpu;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_vec = 0;
  int n_err = 0;

  logic [47:0] sb[$];

  typedef struct {
    string        name;
    int           nb;
    logic [127:0] bytes;
    int           nw;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic         exp_done;
    logic         exp_err;
  } vec_t;

  vec_t tab[4];

  boot_image_loader #(
    .MAGIC          (8'hA5),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .debug     (debug),
    .data_cpu  (data_cpu),
    .waddr_cpu (waddr_cpu),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write-port monitor: every debug pulse must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && debug === 1'b1) begin
      logic [47:0] e;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 waddr_cpu, data_cpu);
      end else begin
        e = sb.pop_front();
        if (waddr_cpu !== {16'h0, e[47:32]} || data_cpu !== e[31:0]) begin
          n_err++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   waddr_cpu, data_cpu, {16'h0, e[47:32]}, e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_clears_done", {31'h0, done}, 32'h0);
    check("start_clears_error", {31'h0, error}, 32'h0);
    check("start_sets_hold", {31'h0, cpu_hold}, 32'h1);
  endtask

  task automatic run_vec(input int i);
    logic [127:0] b;
    b = tab[i].bytes;
    if (tab[i].nw > 0) sb.push_back({16'd0, tab[i].w0});
    if (tab[i].nw > 1) sb.push_back({16'd1, tab[i].w1});
    do_start();
    for (int k = 0; k < tab[i].nb; k++) begin
      send(b[127 - 8*k -: 8]);
    end
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({tab[i].name, "_done"}, {31'h0, done}, {31'h0, tab[i].exp_done});
    check({tab[i].name, "_error"}, {31'h0, error}, {31'h0, tab[i].exp_err});
    check({tab[i].name, "_hold"}, {31'h0, cpu_hold}, {31'h0, ~tab[i].exp_done});
    check({tab[i].name, "_writes_left"}, sb.size(), 32'h0);
    sb.delete();
  endtask

  initial begin
    tab[0] = '{"good", 12, 128'hA5020078563412EFBEADDE28_00000000,
               2, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0};
    tab[1] = '{"badchk", 12, 128'hA5020078563412EFBEADDE29_00000000,
               2, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b1};
    tab[2] = '{"junk", 15, 128'h00FF5AA5020078563412EFBEADDE28_00,
               2, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0};
    tab[3] = '{"len0", 4, 128'hA5000000_000000000000000000000000,
               0, 32'h0, 32'h0, 1'b1, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    rx_byte  = 8'h00;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_debug", {31'h0, debug}, 32'h0);
    check("rst_data", data_cpu, 32'h0);
    check("rst_waddr", waddr_cpu, 32'h0);
    check("rst_hold", {31'h0, cpu_hold}, 32'h1);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_error", {31'h0, error}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(i);

    // Stall after byte 0x56: error exactly 16 edges after the last byte.
    do_start();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h78); send(8'h56);
    rx_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("timeout_early", {31'h0, error}, 32'h0);
    @(negedge clk);
    check("timeout_error", {31'h0, error}, 32'h1);
    check("timeout_hold", {31'h0, cpu_hold}, 32'h1);
    check("timeout_done", {31'h0, done}, 32'h0);

    // Reset in the middle of a back-to-back stream, then reload.
    sb.push_back({16'd0, 32'h12345678});
    do_start();
    send(8'hA5); send(8'h02); send(8'h00); send(8'h78);
    send(8'h56); send(8'h34); send(8'h12); send(8'hEF);
    #2;
    rst      = 1'b1;
    rx_valid = 1'b0;
    #1;
    check("midrst_debug", {31'h0, debug}, 32'h0);
    check("midrst_data", data_cpu, 32'h0);
    check("midrst_waddr", waddr_cpu, 32'h0);
    check("midrst_hold", {31'h0, cpu_hold}, 32'h1);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_error", {31'h0, error}, 32'h0);
    check("midrst_writes_left", sb.size(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boot_image_loader.md
Name: boot_image_loader

Overview:
Bootloader write-side engine that feeds the fetch stage's instruction memory through its debug write port (debug, data_cpu, waddr_cpu).
- Consumes a byte stream from a UART receiver, checks a framed image, and assembles little-endian 32-bit words.
- Issues one single-cycle write strobe per word.
- Holds the CPU in reset until the image verifies.

Parameters:
MAGIC, 8'hA5, frame start byte.
TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes once a frame has started.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a load; accepted only in IDLE, DONE, ERROR.
rx_byte  in  8  received byte.
rx_valid  in  1  rx_byte valid this cycle; may be high every cycle.
debug  out  1  instruction-memory write enable, one-cycle pulse per word.
data_cpu  out  32  word to write.
waddr_cpu  out  32  word index (not a byte address); upper 16 bits always 0.
cpu_hold  out  1  holds the CPU in reset while high.
done  out  1  sticky: image loaded and checksum good.
error  out  1  sticky: checksum mismatch or timeout.

Behaviour:
- Reset values: debug=0, data_cpu=0, waddr_cpu=0, cpu_hold=1, done=0, error=0, state=IDLE; all counters and the checksum are 0.
- Frame format: MAGIC, LEN_LO, LEN_HI, then LEN×4 data bytes (little-endian per word: first byte goes to bits [7:0]), then CHK.
  - CHK = XOR of LEN_LO, LEN_HI and all data bytes.
  - LEN range is 0..65535.
- States: IDLE → WAIT_MAGIC → LEN_LO → LEN_HI → DATA → CHECK → DONE | ERROR.
- IDLE/DONE/ERROR + start → WAIT_MAGIC, with these actions:
  - clear done, error, word counter and checksum;
  - set cpu_hold=1.
  - An rx_valid in the same cycle as start is discarded.
- WAIT_MAGIC: bytes other than MAGIC are discarded. There is no timeout in this state.
- LEN_LO/LEN_HI: capture the length and XOR it into the checksum. After LEN_HI:
  - if LEN=0, go to CHECK;
  - otherwise go to DATA.
- DATA: a 2-bit byte-lane counter shifts bytes into the assembly register and XORs each into the checksum.
  - On the 4th byte, the following occurs on the next posedge:
    - data_cpu = assembled word;
    - waddr_cpu = word count;
    - debug = 1 for exactly one cycle (the fetch stage samples it on the intervening negedge).
  - The word count increments after each word.
  - When word count reaches LEN, go to CHECK.
  - There is no WRITE wait state, so back-to-back bytes are never dropped.
- data_cpu and waddr_cpu hold their last values between pulses.
- CHECK: on the next byte:
  - if byte == checksum: go to DONE, set done=1 and cpu_hold=0 on the following posedge;
  - otherwise: go to ERROR, set error=1, keep cpu_hold=1.
- Timeout: in LEN_LO, LEN_HI, DATA and CHECK, an idle counter resets on every rx_valid. When it reaches TIMEOUT_CYCLES, go to ERROR with error=1.
- start while a frame is in progress (WAIT_MAGIC..CHECK) is ignored.
- rst mid-frame returns everything to reset values. Words already written stay in memory; the next load restarts at index 0.
- A word counter wrap is impossible because LEN ≤ 65535 and the counter is 17 bits.

Decomposition:
- Package boot_pkg holds:
  - the state enum (IDLE, WAIT_MAGIC, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR);
  - the default MAGIC value;
  - WORD_W=32, IDX_W=16.
- One natural sub-module, boot_word_assembler: byte-lane counter, shift register and word_ready strobe. The FSM, checksum and timeout stay in the top module.

Test Plan:
1. start; bytes A5 02 00 78 56 34 12 EF BE AD DE 28 → debug pulse with waddr_cpu=0 / data_cpu=32'h12345678, then waddr_cpu=1 / data_cpu=32'hDEADBEEF; done=1, cpu_hold=0, error=0.
2. Same frame with CHK=29 → both writes still occur; error=1, done=0, cpu_hold=1.
3. Bytes 00 FF 5A precede the frame of test 1 → identical writes and result (junk ignored).
4. start; A5 00 00 00 → no debug pulse; done=1, cpu_hold=0.
5. TIMEOUT_CYCLES=16; frame of test 1 stops after byte 56 → error=1 exactly 16 cycles after the last rx_valid, no debug pulse.
6. rst asserted during DATA of a back-to-back (rx_valid every cycle) stream → outputs go to reset values immediately; a subsequent start plus the full frame from test 1 gives writes at indices 0 and 1 and done=1.
